// File: rtl/link_fifo_if.sv
// link_fifo_if: enqueue/dequeue valid-ready stream bundle for link_fifo_ctrl.
// The master side produces enq words and consumes deq words.
// The slave side is the FIFO controller itself.
interface link_fifo_if #(
  parameter int DWIDTH = 32
);
  logic              enq_valid;
  logic              enq_ready;
  logic [DWIDTH-1:0] enq_data;
  logic              deq_valid;
  logic              deq_ready;
  logic [DWIDTH-1:0] deq_data;

  modport master (
    output enq_valid, enq_data, deq_ready,
    input  enq_ready, deq_valid, deq_data
  );

  modport slave (
    input  enq_valid, enq_data, deq_ready,
    output enq_ready, deq_valid, deq_data
  );
endinterface

// File: rtl/link_fifo_ctrl.sv
// link_fifo_ctrl: valid/ready FIFO controller wrapped around an external link_fifo_ram.
// Latency: enqueue into an empty FIFO shows on deq 2+RDLAT cycles later; 1 word/clk sustained.
// Backpressure: enq_ready drops only when the RAM holds DEPTH words; deq_data holds while deq_ready is low.
module link_fifo_ctrl #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 1024,
  parameter int DOREG  = 1,
  localparam int AW    = $clog2(DEPTH),
  localparam int RDLAT = 1 + DOREG,
  localparam int OBUF  = RDLAT + 1,
  localparam int CW    = $clog2(DEPTH + OBUF) + 1
) (
  input  logic              clk,
  input  logic              rst,
  link_fifo_if.slave        lnk,
  output logic              ram_we,
  output logic [AW-1:0]     ram_waddr,
  output logic [DWIDTH-1:0] ram_din,
  output logic [AW-1:0]     ram_raddr,
  input  logic [DWIDTH-1:0] ram_dout,
  output logic [CW-1:0]     count
);
  localparam int          OW       = $clog2(OBUF + 1);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];
  localparam logic [3:0]  OBUF_CR  = OBUF[3:0];

  logic [AW-1:0]     wptr;
  logic [AW-1:0]     rptr;
  logic [AW:0]       ram_cnt;
  logic [RDLAT-1:0]  inflight;
  logic [OW-1:0]     obuf_cnt;
  logic [OW-1:0]     wr_idx;
  logic [DWIDTH-1:0] obuf     [OBUF];
  logic [DWIDTH-1:0] obuf_nxt [OBUF];
  logic [3:0]        credit_used;
  logic              enq_fire;
  logic              rd_iss;
  logic              push;
  logic              pop;

  assign lnk.enq_ready = !rst && (ram_cnt < FULL_CNT);
  assign lnk.deq_valid = (obuf_cnt != '0);
  assign lnk.deq_data  = obuf[0];
  assign ram_we        = enq_fire;
  assign ram_waddr     = wptr;
  assign ram_din       = lnk.enq_data;
  assign ram_raddr     = rptr;

  // Handshake decode and read-issue credit check. A slot popped this cycle is
  // counted as free: the read issued now lands at least RDLAT cycles later, so
  // reusing that slot keeps the dequeue side bubble-free with OBUF = RDLAT+1.
  always_comb begin
    enq_fire    = lnk.enq_valid && lnk.enq_ready;
    pop         = lnk.deq_valid && lnk.deq_ready;
    push        = inflight[RDLAT-1];
    credit_used = 4'(obuf_cnt) - 4'(pop);
    for (int i = 0; i < RDLAT; i++) begin
      credit_used = credit_used + 4'(inflight[i]);
    end
    rd_iss = (ram_cnt != '0) && (credit_used < OBUF_CR);
  end

  // Output buffer next state: shift toward the head on pop, land RAM data behind the last valid entry.
  always_comb begin
    obuf_nxt = obuf;
    wr_idx   = obuf_cnt - OW'(pop);
    if (pop) begin
      for (int i = 0; i < OBUF - 1; i++) begin
        obuf_nxt[i] = obuf[i+1];
      end
    end
    if (push) begin
      for (int i = 0; i < OBUF; i++) begin
        if (OW'(i) == wr_idx) obuf_nxt[i] = ram_dout;
      end
    end
  end

  // Pointers, RAM occupancy, read tag pipe and total count; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr     <= '0;
      rptr     <= '0;
      ram_cnt  <= '0;
      inflight <= '0;
      count    <= '0;
    end else begin
      if (enq_fire) wptr <= wptr + 1'b1;
      if (rd_iss)   rptr <= rptr + 1'b1;
      ram_cnt <= ram_cnt + (AW+1)'(enq_fire) - (AW+1)'(rd_iss);
      for (int i = RDLAT - 1; i > 0; i--) begin
        inflight[i] <= inflight[i-1];
      end
      inflight[0] <= rd_iss;
      count <= count + CW'(enq_fire) - CW'(pop);
    end
  end

  // Output buffer storage; the head entry is the registered deq_data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      obuf_cnt <= '0;
      for (int i = 0; i < OBUF; i++) begin
        obuf[i] <= '0;
      end
    end else begin
      obuf_cnt <= obuf_cnt + OW'(push) - OW'(pop);
      obuf     <= obuf_nxt;
    end
  end
endmodule

// File: tb/tb_link_fifo_ctrl.sv
// tb_link_fifo_ctrl: drives a DOREG=1 and a DOREG=0 controller (DEPTH=16) with identical stimulus,
// each backed by a behavioural READ_FIRST RAM, and scores both against a word-queue reference.
// Index 0 is the DOREG=1 instance, index 1 the DOREG=0 instance.
module tb_link_fifo_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enq_valid = 1'b0;
  logic [31:0] enq_data = '0;
  logic        deq_ready = 1'b0;

  always #5 clk = ~clk;

  link_fifo_if #(.DWIDTH(32)) if0 ();
  link_fifo_if #(.DWIDTH(32)) if1 ();

  assign if0.enq_valid = enq_valid;
  assign if0.enq_data  = enq_data;
  assign if0.deq_ready = deq_ready;
  assign if1.enq_valid = enq_valid;
  assign if1.enq_data  = enq_data;
  assign if1.deq_ready = deq_ready;

  logic        we0, we1;
  logic [3:0]  wa0, wa1, ra0, ra1;
  logic [31:0] din0, din1, dout0, dout1;
  logic [5:0]  cnt0, cnt1;

  link_fifo_ctrl #(.DWIDTH(32), .DEPTH(16), .DOREG(1)) dut0 (
    .clk(clk), .rst(rst), .lnk(if0), .ram_we(we0), .ram_waddr(wa0), .ram_din(din0),
    .ram_raddr(ra0), .ram_dout(dout0), .count(cnt0));
  link_fifo_ctrl #(.DWIDTH(32), .DEPTH(16), .DOREG(0)) dut1 (
    .clk(clk), .rst(rst), .lnk(if1), .ram_we(we1), .ram_waddr(wa1), .ram_din(din1),
    .ram_raddr(ra1), .ram_dout(dout1), .count(cnt1));

  // Behavioural RAMs: READ_FIRST, read latency 2 (output register) and 1.
  logic [31:0] mem0 [16];
  logic [31:0] mem1 [16];
  logic [31:0] r0a, r0b, r1a;
  always @(posedge clk) begin
    if (we0) mem0[wa0] <= din0;
    r0a <= mem0[ra0];
    r0b <= r0a;
    if (we1) mem1[wa1] <= din1;
    r1a <= mem1[ra1];
  end
  assign dout0 = r0b;
  assign dout1 = r1a;

  // Per-instance views of DUT outputs.
  logic        ery  [2];
  logic        dvl  [2];
  logic [31:0] ddat [2];
  logic [5:0]  cnt  [2];
  logic        we   [2];
  logic [3:0]  wa   [2];
  logic [3:0]  ra   [2];
  assign ery[0] = if0.enq_ready;  assign ery[1] = if1.enq_ready;
  assign dvl[0] = if0.deq_valid;  assign dvl[1] = if1.deq_valid;
  assign ddat[0] = if0.deq_data;  assign ddat[1] = if1.deq_data;
  assign cnt[0] = cnt0;           assign cnt[1] = cnt1;
  assign we[0] = we0;             assign we[1] = we1;
  assign wa[0] = wa0;             assign wa[1] = wa1;
  assign ra[0] = ra0;             assign ra[1] = ra1;

  int cap [2] = '{19, 18};
  int lat [2] = '{4, 3};

  // Reference model: the words held, oldest first.
  logic [31:0] mq [2][$];

  // Per-cycle samples taken by tick().
  logic        s_ery [2];
  logic        s_vld [2];
  logic        s_pop [2];
  logic [31:0] s_dat [2];
  logic [5:0]  s_cnt [2];
  logic [31:0] e_dat [2];
  int          e_cnt [2];
  int          wraps [2];

  int total  = 0;
  int passed = 0;

  task automatic model_clear();
    for (int d = 0; d < 2; d++) mq[d].delete();
  endtask

  // One clock: sample outputs mid-cycle, advance the reference model, step to just after the next edge.
  task automatic tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s_ery[d] = ery[d];
      s_vld[d] = dvl[d];
      s_dat[d] = ddat[d];
      s_cnt[d] = cnt[d];
      s_pop[d] = dvl[d] && deq_ready;
      e_cnt[d] = mq[d].size();
      e_dat[d] = (mq[d].size() != 0) ? mq[d][0] : 32'hx;
      if (we[d] && wa[d] == 4'hF) wraps[d]++;
      if (s_pop[d] && mq[d].size() != 0) void'(mq[d].pop_front());
      if (enq_valid && ery[d]) mq[d].push_back(enq_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    enq_valid = 1'b0;
    deq_ready = 1'b0;
    rst = 1'b1;
    #3;
    for (int d = 0; d < 2; d++) begin
      total += 7;
      if (ery[d] !== 1'b0) $display("FAIL reset_enq_ready[%0d] got %b want 0", d, ery[d]); else passed++;
      if (dvl[d] !== 1'b0) $display("FAIL reset_deq_valid[%0d] got %b want 0", d, dvl[d]); else passed++;
      if (ddat[d] !== 32'h0) $display("FAIL reset_deq_data[%0d] got %h want 0", d, ddat[d]); else passed++;
      if (cnt[d] !== 6'd0) $display("FAIL reset_count[%0d] got %0d want 0", d, cnt[d]); else passed++;
      if (we[d] !== 1'b0) $display("FAIL reset_ram_we[%0d] got %b want 0", d, we[d]); else passed++;
      if (wa[d] !== 4'h0) $display("FAIL reset_waddr[%0d] got %0d want 0", d, wa[d]); else passed++;
      if (ra[d] !== 4'h0) $display("FAIL reset_raddr[%0d] got %0d want 0", d, ra[d]); else passed++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    #1;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (ery[d] !== 1'b1) $display("FAIL release_enq_ready[%0d] got %b want 1", d, ery[d]); else passed++;
    end
  endtask

  task automatic test_latency();
    do_reset();
    enq_valid = 1'b1;
    enq_data  = 32'hA5A5_0001;
    tick();
    enq_valid = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        total += 2;
        if (s_cnt[d] !== 6'd1) $display("FAIL lat_count[%0d] cyc %0d got %0d want 1", d, c, s_cnt[d]); else passed++;
        if (s_vld[d] !== (c >= lat[d])) $display("FAIL lat_deq_valid[%0d] cyc %0d got %b want %b", d, c, s_vld[d], c >= lat[d]);
        else passed++;
        if (c == lat[d]) begin
          total++;
          if (s_dat[d] !== 32'hA5A5_0001) $display("FAIL lat_deq_data[%0d] got %h want a5a50001", d, s_dat[d]); else passed++;
        end
      end
    end
  endtask

  task automatic test_stream();
    int first [2] = '{-1, -1};
    int last  [2] = '{-1, -1};
    int npop  [2] = '{0, 0};
    do_reset();
    wraps[0] = 0;
    wraps[1] = 0;
    deq_ready = 1'b1;
    for (int c = 0; c < 160; c++) begin
      enq_valid = (c < 100);
      enq_data  = 32'(c);
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (s_cnt[d] !== 6'(e_cnt[d])) $display("FAIL stream_count[%0d] cyc %0d got %0d want %0d", d, c, s_cnt[d], e_cnt[d]);
        else passed++;
        if (s_pop[d]) begin
          total++;
          if (s_dat[d] !== e_dat[d]) $display("FAIL stream_data[%0d] cyc %0d got %h want %h", d, c, s_dat[d], e_dat[d]);
          else passed++;
          if (first[d] < 0) first[d] = c;
          last[d] = c;
          npop[d]++;
        end
      end
      if (c >= 100 && mq[0].size() == 0 && mq[1].size() == 0) break;
    end
    enq_valid = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total += 3;
      if (npop[d] != 100) $display("FAIL stream_words[%0d] got %0d want 100", d, npop[d]); else passed++;
      if (last[d] - first[d] != 99) $display("FAIL stream_rate[%0d] span %0d want 99", d, last[d] - first[d]); else passed++;
      if (wraps[d] != 6) $display("FAIL stream_wraps[%0d] got %0d want 6", d, wraps[d]); else passed++;
    end
  endtask

  task automatic test_full();
    bit done = 1'b0;
    bit seen [2] = '{1'b0, 1'b0};
    do_reset();
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int c = 0; c < 60 && !done; c++) begin
      enq_data = 32'h1000_0000 + 32'(c);
      tick();
      done = !s_ery[0] && !s_ery[1];
    end
    total++;
    if (!done) $display("FAIL full_reached got enq_ready %b/%b want 0/0", s_ery[0], s_ery[1]); else passed++;
    tick();
    tick();
    enq_valid = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      total += 2;
      if (s_cnt[d] !== 6'(cap[d])) $display("FAIL full_count[%0d] got %0d want %0d", d, s_cnt[d], cap[d]); else passed++;
      if (s_ery[d] !== 1'b0) $display("FAIL full_enq_ready[%0d] got %b want 0", d, s_ery[d]); else passed++;
    end
    deq_ready = 1'b1;
    tick();
    deq_ready = 1'b0;
    for (int d = 0; d < 2; d++) begin
      total++;
      if (s_dat[d] !== e_dat[d]) $display("FAIL full_pop_data[%0d] got %h want %h", d, s_dat[d], e_dat[d]); else passed++;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      for (int d = 0; d < 2; d++) if (s_ery[d]) seen[d] = 1'b1;
    end
    for (int d = 0; d < 2; d++) begin
      total += 2;
      if (seen[d] !== 1'b1) $display("FAIL full_reopen[%0d] got enq_ready 0 want 1 within 2 cycles", d); else passed++;
      if (s_cnt[d] !== 6'(cap[d] - 1)) $display("FAIL full_count_after_pop[%0d] got %0d want %0d", d, s_cnt[d], cap[d] - 1);
      else passed++;
    end
  endtask

  task automatic test_random();
    bit          hold  [2] = '{1'b0, 1'b0};
    logic [31:0] hdat  [2];
    enq_valid = 1'b1;
    deq_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      enq_data = $urandom;
      tick();
    end
    for (int c = 0; c < 2000; c++) begin
      enq_valid = 1'($urandom_range(0, 1));
      deq_ready = 1'($urandom_range(0, 1));
      enq_data  = $urandom;
      tick();
      for (int d = 0; d < 2; d++) begin
        total++;
        if (s_cnt[d] !== 6'(e_cnt[d])) $display("FAIL rand_count[%0d] cyc %0d got %0d want %0d", d, c, s_cnt[d], e_cnt[d]);
        else passed++;
        if (s_pop[d]) begin
          total++;
          if (s_dat[d] !== e_dat[d]) $display("FAIL rand_data[%0d] cyc %0d got %h want %h", d, c, s_dat[d], e_dat[d]);
          else passed++;
        end
        if (e_cnt[d] == cap[d]) begin
          total++;
          if (s_ery[d] !== 1'b0) $display("FAIL rand_full_ready[%0d] cyc %0d got 1 want 0", d, c); else passed++;
        end
        if (hold[d] && s_vld[d]) begin
          total++;
          if (s_dat[d] !== hdat[d]) $display("FAIL rand_hold[%0d] cyc %0d got %h want %h", d, c, s_dat[d], hdat[d]);
          else passed++;
        end
        if (hold[d] && !s_vld[d]) begin
          total++;
          $display("FAIL rand_valid_drop[%0d] cyc %0d got deq_valid 0 want 1", d, c);
        end
        hold[d] = s_vld[d] && !deq_ready;
        hdat[d] = s_dat[d];
      end
    end
    enq_valid = 1'b0;
    deq_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (s_pop[d]) begin
          total++;
          if (s_dat[d] !== e_dat[d]) $display("FAIL drain_data[%0d] got %h want %h", d, s_dat[d], e_dat[d]); else passed++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      total += 2;
      if (mq[d].size() != 0) $display("FAIL drain_left[%0d] got %0d words undelivered want 0", d, mq[d].size()); else passed++;
      if (cnt[d] !== 6'd0) $display("FAIL drain_count[%0d] got %0d want 0", d, cnt[d]); else passed++;
    end
  endtask

  task automatic test_reset_midstream();
    bit got [2] = '{1'b0, 1'b0};
    do_reset();
    deq_ready = 1'b0;
    enq_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      enq_data = 32'h0000_0100 + 32'(k);
      tick();
    end
    enq_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      total += 2;
      if (dvl[d] !== 1'b0) $display("FAIL midrst_deq_valid[%0d] got %b want 0", d, dvl[d]); else passed++;
      if (cnt[d] !== 6'd0) $display("FAIL midrst_count[%0d] got %0d want 0", d, cnt[d]); else passed++;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    tick();
    deq_ready = 1'b1;
    enq_valid = 1'b1;
    enq_data  = 32'h0000_BEEF;
    tick();
    enq_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        if (s_pop[d] && !got[d]) begin
          got[d] = 1'b1;
          total++;
          if (s_dat[d] !== 32'h0000_BEEF) $display("FAIL midrst_first_word[%0d] got %h want 0000beef", d, s_dat[d]);
          else passed++;
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (!got[d]) begin
        total++;
        $display("FAIL midrst_timeout[%0d] got no dequeue want 0000beef", d);
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_stream();
    test_full();
    test_random();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
